// File: rtl/store_buffer_if.sv
// Memory-side channels of the store buffer: a posted write channel and a
// combinational read port used for load data.
interface store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_wvalid;
  logic          mem_wready;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  // Buffer side.
  modport master (
    output mem_wvalid, mem_waddr, mem_wdata, mem_raddr,
    input  mem_wready, mem_rdata
  );

  // Memory side.
  modport slave (
    input  mem_wvalid, mem_waddr, mem_wdata, mem_raddr,
    output mem_wready, mem_rdata
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the Memory stage and data memory, with
// youngest-store forwarding to Memory-stage loads at word granularity.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWriteM,
  input  logic [AW-1:0] ALUOutM,
  input  logic [DW-1:0] WriteDataM,
  output logic [DW-1:0] ReadDataM,
  output logic          StallSB,
  output logic          SBEmpty,
  store_buffer_if.master memBus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    entryAddr [DEPTH];
  logic [DW-1:0]    entryData [DEPTH];
  logic [DEPTH-1:0] entryValid;
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    count;

  logic full;
  logic push;
  logic pop;

  // Write channel: mem_wvalid/mem_waddr/mem_wdata present the head entry and
  // stay unchanged until a rising edge where mem_wvalid and mem_wready are both
  // high; that edge is the transfer and the head advances.
  assign full    = (count == CW'(DEPTH));
  assign SBEmpty = (count == '0);
  assign StallSB = MemWriteM & full;

  // full is judged on the registered count, so a same-cycle pop never frees a slot
  assign push = MemWriteM & ~full;
  assign pop  = memBus.mem_wvalid & memBus.mem_wready;

  assign memBus.mem_wvalid = (count != '0);
  assign memBus.mem_waddr  = entryAddr[rdPtr];
  assign memBus.mem_wdata  = entryData[rdPtr];
  assign memBus.mem_raddr  = ALUOutM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      entryValid <= '0;
    end else begin
      if (pop) begin
        entryValid[rdPtr] <= 1'b0;
        rdPtr             <= rdPtr + PW'(1);
      end
      if (push) begin
        entryValid[wrPtr] <= 1'b1;
        wrPtr             <= wrPtr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entryAddr[wrPtr] <= ALUOutM;
      entryData[wrPtr] <= WriteDataM;
    end
  end

  // Walk from oldest slot to youngest (just before wrPtr); the last hit wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    ReadDataM = memBus.mem_rdata;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wrPtr - PW'(k);
      if (entryValid[idx] && (entryAddr[idx][AW-1:2] == ALUOutM[AW-1:2])) begin
        ReadDataM = entryData[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a per-cycle vector table plus hand-written
// sequences for reset, backpressure wrap-around and write-order scoreboarding.
module tb_store_buffer;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          MemWriteM;
  logic [AW-1:0] ALUOutM;
  logic [DW-1:0] WriteDataM;
  logic [DW-1:0] ReadDataM;
  logic          StallSB;
  logic          SBEmpty;

  store_buffer_if #(.AW(AW), .DW(DW)) bus ();

  store_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallSB    (StallSB),
    .SBEmpty    (SBEmpty),
    .memBus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got still running, expected done");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // A transfer happens at the next rising edge when valid and ready are both
  // high at the falling edge (inputs only change just after rising edges).
  always @(negedge clk) begin
    if (reset && bus.mem_wvalid && bus.mem_wready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.mem_waddr, bus.mem_wdata);
      end else begin
        check("write_order", {bus.mem_waddr, bus.mem_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic wr, input logic [DW-1:0] rd);
    MemWriteM      = mw;
    ALUOutM        = a;
    WriteDataM     = wd;
    bus.mem_wready = wr;
    bus.mem_rdata  = rd;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          mw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          wr;
    logic [DW-1:0] rd;
    logic          eStall;
    logic          eEmpty;
    logic          eValid;
    logic [AW-1:0] eWaddr;
    logic [DW-1:0] eWdata;
    logic [DW-1:0] eRead;
  } vec_t;

  function automatic vec_t mk(input logic mw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                              input logic wr, input logic [DW-1:0] rd, input logic eStall,
                              input logic eEmpty, input logic eValid, input logic [AW-1:0] eWaddr,
                              input logic [DW-1:0] eWdata, input logic [DW-1:0] eRead);
    vec_t v;
    v.mw = mw; v.addr = addr; v.wd = wd; v.wr = wr; v.rd = rd;
    v.eStall = eStall; v.eEmpty = eEmpty; v.eValid = eValid;
    v.eWaddr = eWaddr; v.eWdata = eWdata; v.eRead = eRead;
    return v;
  endfunction

  localparam int NVEC = 24;
  vec_t vecs[NVEC];

  initial begin
    int cnt;
    int issued;
    int cyc;
    logic acc;
    logic popm;

    vecs[0]  = mk(1, 'h10,  'hDEADBEEF, 1, 'h11111111, 0, 1, 0, 0,      0,           'h11111111);
    vecs[1]  = mk(0, 'h10,  0,          1, 'h22222222, 0, 0, 1, 'h10,   'hDEADBEEF,  'hDEADBEEF);
    vecs[2]  = mk(0, 'h10,  0,          1, 'h33333333, 0, 1, 0, 0,      0,           'h33333333);
    vecs[3]  = mk(1, 'h100, 'hA0,       0, 'h44,       0, 1, 0, 0,      0,           'h44);
    vecs[4]  = mk(1, 'h104, 'hA1,       0, 'h45,       0, 0, 1, 'h100,  'hA0,        'h45);
    vecs[5]  = mk(1, 'h108, 'hA2,       0, 'h46,       0, 0, 1, 'h100,  'hA0,        'h46);
    vecs[6]  = mk(1, 'h10C, 'hA3,       0, 'h47,       0, 0, 1, 'h100,  'hA0,        'h47);
    vecs[7]  = mk(1, 'h110, 'hA4,       0, 'h48,       1, 0, 1, 'h100,  'hA0,        'h48);
    vecs[8]  = mk(1, 'h110, 'hA4,       1, 'h49,       1, 0, 1, 'h100,  'hA0,        'h49);
    vecs[9]  = mk(1, 'h110, 'hA4,       1, 'h4A,       0, 0, 1, 'h104,  'hA1,        'h4A);
    vecs[10] = mk(0, 'h110, 0,          1, 'h4B,       0, 0, 1, 'h108,  'hA2,        'hA4);
    vecs[11] = mk(0, 'h10C, 0,          0, 'h4C,       0, 0, 1, 'h10C,  'hA3,        'hA3);
    vecs[12] = mk(1, 'h200, 'hB0,       1, 'h4D,       0, 0, 1, 'h10C,  'hA3,        'h4D);
    vecs[13] = mk(0, 'h200, 0,          0, 'h4E,       0, 0, 1, 'h110,  'hA4,        'hB0);
    vecs[14] = mk(0, 'h300, 0,          1, 'h4F,       0, 0, 1, 'h110,  'hA4,        'h4F);
    vecs[15] = mk(0, 'h0,   0,          1, 'h50,       0, 0, 1, 'h200,  'hB0,        'h50);
    vecs[16] = mk(0, 'h20,  0,          0, 'h51,       0, 1, 0, 0,      0,           'h51);
    vecs[17] = mk(1, 'h20,  1,          0, 'h52,       0, 1, 0, 0,      0,           'h52);
    vecs[18] = mk(1, 'h20,  2,          0, 'h53,       0, 0, 1, 'h20,   1,           1);
    vecs[19] = mk(0, 'h22,  0,          0, 'h54,       0, 0, 1, 'h20,   1,           2);
    vecs[20] = mk(0, 'h24,  0,          0, 'h1234,     0, 0, 1, 'h20,   1,           'h1234);
    vecs[21] = mk(0, 'h23,  0,          1, 'h56,       0, 0, 1, 'h20,   1,           2);
    vecs[22] = mk(0, 'h20,  0,          1, 'h57,       0, 0, 1, 'h20,   2,           2);
    vecs[23] = mk(0, 'h20,  0,          0, 'h58,       0, 1, 0, 0,      0,           'h58);

    // ---- initial reset ----
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1;
    check("reset_wvalid", bus.mem_wvalid, 0);
    check("reset_empty", SBEmpty, 1);
    check("reset_stall", StallSB, 0);
    repeat (2) tick();
    reset = 1'b1;

    // ---- reset with pending stores discards them ----
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h40 + 32'(4 * i), 32'h900 + 32'(i), 0, 0);
      tick();
    end
    drive(1, 32'h50, 32'h999, 0, 0);
    @(negedge clk);
    check("full_stall", StallSB, 1);
    check("full_wvalid", bus.mem_wvalid, 1);
    tick();
    reset = 1'b0;
    #1;
    check("midrst_wvalid", bus.mem_wvalid, 0);
    check("midrst_empty", SBEmpty, 1);
    check("midrst_stall", StallSB, 0);
    tick();
    drive(0, 32'h40, 0, 1, 32'h77);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_wvalid", bus.mem_wvalid, 0);
      check("postrst_empty", SBEmpty, 1);
      check("postrst_fwd", ReadDataM, 32'h77);
      tick();
    end

    // ---- table: single store, backpressure, push+pop, forwarding ----
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].mw, vecs[i].addr, vecs[i].wd, vecs[i].wr, vecs[i].rd);
      @(negedge clk);
      check($sformatf("v%0d_stall", i), StallSB, vecs[i].eStall);
      check($sformatf("v%0d_empty", i), SBEmpty, vecs[i].eEmpty);
      check($sformatf("v%0d_wvalid", i), bus.mem_wvalid, vecs[i].eValid);
      check($sformatf("v%0d_raddr", i), bus.mem_raddr, vecs[i].addr);
      check($sformatf("v%0d_rdata", i), ReadDataM, vecs[i].eRead);
      if (vecs[i].eValid) begin
        check($sformatf("v%0d_waddr", i), bus.mem_waddr, vecs[i].eWaddr);
        check($sformatf("v%0d_wdata", i), bus.mem_wdata, vecs[i].eWdata);
      end
      tick();
      if (vecs[i].mw && !vecs[i].eStall) exp_q.push_back({vecs[i].addr, vecs[i].wd});
    end

    // ---- wrap-around: 10 stores with alternating ready ----
    cnt = 0;
    issued = 0;
    cyc = 0;
    while (issued < 10 && cyc < 60) begin
      drive(1, 32'h400 + 32'(4 * issued), 32'hC0000000 + 32'(issued), logic'(cyc % 2), 32'h5A5A);
      @(negedge clk);
      check("wrap_stall", StallSB, (cnt == 4));
      check("wrap_wvalid", bus.mem_wvalid, (cnt != 0));
      acc  = (cnt < 4);
      popm = (cnt != 0) && (cyc % 2 == 1);
      tick();
      if (acc) begin
        exp_q.push_back({32'h400 + 32'(4 * issued), 32'hC0000000 + 32'(issued)});
        issued++;
      end
      cnt = cnt + int'(acc) - int'(popm);
      cyc++;
    end
    check("wrap_issued", issued, 10);

    drive(0, 32'h0, 0, 1, 32'h0);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    @(negedge clk);
    check("drain_remaining", exp_q.size(), 0);
    check("drain_empty", SBEmpty, 1);
    check("drain_wvalid", bus.mem_wvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
